// File: rtl/recon_sequencer.sv
// Reconstruction sequencer: walks chroma 8x8 blocks in raster order and their four
// luma 4x4 sub-blocks in Z-order, handshaking extract/predict/commit stages.
module recon_sequencer #(
  parameter int WIDTH   = 1280,
  parameter int LENGTH  = 720,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic        fb_luma4x4,
  input  logic        fb_chromab8x8,
  input  logic        fb_chromar8x8,
  output logic [2:0]  enabler,
  output logic [31:0] mbnumber_luma4x4,
  output logic [31:0] mbnumber_chromab8x8,
  output logic [31:0] mbnumber_chromar8x8,
  output logic        commit_chroma,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam logic [31:0] CX_LAST       = 32'(WIDTH / 8 - 1);
  localparam logic [31:0] CY_LAST       = 32'(LENGTH / 8 - 1);
  localparam logic [31:0] LUMA_STRIDE   = 32'(WIDTH / 4);
  localparam logic [31:0] CHROMA_STRIDE = 32'(WIDTH / 8);
  localparam logic [31:0] TO_LAST       = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RES, S_EXTRACT, S_PREDICT, S_COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cx_q, cy_q, cnt_q;
  logic [31:0] cx_d, cy_d;
  logic [1:0]  k_q, k_d;
  logic        flag_l_q, flag_b_q, flag_r_q;
  logic        seen_l, seen_b, seen_r;
  logic        exit_ok, last_blk, timed_out;
  logic [31:0] luma_q, chroma_q;
  logic        busy_q, frame_done_q, timeout_err_q;

  function automatic logic [31:0] luma_idx(input logic [31:0] cx, input logic [31:0] cy,
                                           input logic [1:0] k);
    luma_idx = ((cy << 1) + {31'b0, k[1]}) * LUMA_STRIDE + (cx << 1) + {31'b0, k[0]};
  endfunction

  function automatic logic [31:0] chroma_idx(input logic [31:0] cx, input logic [31:0] cy);
    chroma_idx = cy * CHROMA_STRIDE + cx;
  endfunction

  // A pulse arriving in the deciding cycle counts together with the sticky flags.
  assign seen_l    = flag_l_q | fb_luma4x4;
  assign seen_b    = flag_b_q | fb_chromab8x8;
  assign seen_r    = flag_r_q | fb_chromar8x8;
  assign exit_ok   = seen_l && ((k_q != 2'd0) || (seen_b && seen_r));
  assign last_blk  = (cx_q == CX_LAST) && (cy_q == CY_LAST) && (k_q == 2'd3);
  assign timed_out = (cnt_q == TO_LAST);

  assign k_d  = k_q + 2'd1;
  assign cx_d = (k_q == 2'd3) ? ((cx_q == CX_LAST) ? 32'd0 : cx_q + 32'd1) : cx_q;
  assign cy_d = ((k_q == 2'd3) && (cx_q == CX_LAST)) ? cy_q + 32'd1 : cy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_WAIT_RES;
      S_WAIT_RES: if (res_valid) state_d = S_EXTRACT;
      S_EXTRACT:  state_d = S_PREDICT;
      S_PREDICT: begin
        if (exit_ok)        state_d = S_COMMIT;
        else if (timed_out) state_d = S_IDLE;
      end
      S_COMMIT:   state_d = last_blk ? S_IDLE : S_WAIT_RES;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enabler       = 3'b000;
    res_ready     = 1'b0;
    commit_chroma = 1'b0;
    case (state_q)
      S_WAIT_RES: res_ready = 1'b1;
      S_EXTRACT:  enabler   = 3'b001;
      S_PREDICT:  enabler   = 3'b010;
      S_COMMIT: begin
        enabler       = 3'b100;
        commit_chroma = (k_q == 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_q          <= '0;
      cy_q          <= '0;
      k_q           <= '0;
      cnt_q         <= '0;
      flag_l_q      <= 1'b0;
      flag_b_q      <= 1'b0;
      flag_r_q      <= 1'b0;
      luma_q        <= '0;
      chroma_q      <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          cx_q          <= '0;
          cy_q          <= '0;
          k_q           <= '0;
          timeout_err_q <= 1'b0;
          busy_q        <= 1'b1;
        end
        S_WAIT_RES: if (res_valid) begin
          luma_q   <= luma_idx(cx_q, cy_q, k_q);
          chroma_q <= chroma_idx(cx_q, cy_q);
        end
        S_EXTRACT: begin
          flag_l_q <= 1'b0;
          flag_b_q <= 1'b0;
          flag_r_q <= 1'b0;
          cnt_q    <= '0;
        end
        S_PREDICT: begin
          flag_l_q <= seen_l;
          flag_b_q <= seen_b;
          flag_r_q <= seen_r;
          cnt_q    <= cnt_q + 32'd1;
          if (!exit_ok && timed_out) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        S_COMMIT: begin
          k_q  <= k_d;
          cx_q <= cx_d;
          cy_q <= cy_d;
          if (last_blk) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mbnumber_luma4x4    = luma_q;
  assign mbnumber_chromab8x8 = chroma_q;
  assign mbnumber_chromar8x8 = chroma_q;
  assign busy                = busy_q;
  assign frame_done          = frame_done_q;
  assign timeout_err         = timeout_err_q;

endmodule

// File: tb/tb_recon_sequencer.sv
// Bench for recon_sequencer: randomized feedback timing, scoreboard of expected
// commits from a block-index model, plus reset, timeout and stray-input scenarios.
module tb_recon_sequencer;
  localparam int W = 16, L = 16, TO = 8;
  localparam int CW = W / 8, CH = L / 8, NSUB = CW * CH * 4;

  logic clk = 1'b0;
  logic reset, start, res_valid, fb_l, fb_b, fb_r;
  logic res_ready, commit_chroma, busy, frame_done, timeout_err;
  logic [2:0] enabler;
  logic [31:0] mb_l, mb_b, mb_r;

  recon_sequencer #(.WIDTH(W), .LENGTH(L), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .res_valid(res_valid), .res_ready(res_ready),
    .fb_luma4x4(fb_l), .fb_chromab8x8(fb_b), .fb_chromar8x8(fb_r), .enabler(enabler),
    .mbnumber_luma4x4(mb_l), .mbnumber_chromab8x8(mb_b), .mbnumber_chromar8x8(mb_r),
    .commit_chroma(commit_chroma), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] luma;
    logic [31:0] chroma;
    logic        cc;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, commits = 0, cc_cnt = 0, done_cnt = 0;
  logic [31:0] lat_l, lat_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sub-block n of the frame: chroma blocks raster order, four luma quadrants each.
  function automatic exp_t model(input int n);
    exp_t e;
    int cx, cy, k;
    k  = n % 4;
    cx = (n / 4) % CW;
    cy = n / (4 * CW);
    e.luma   = 32'((2 * cy + k / 2) * (W / 4) + 2 * cx + k % 2);
    e.chroma = 32'(cy * CW + cx);
    e.cc     = (k == 0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enabler"}, {29'b0, enabler}, 0);
    chk({tag, "_res_ready"}, {31'b0, res_ready}, 0);
    chk({tag, "_commit_chroma"}, {31'b0, commit_chroma}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_frame_done"}, {31'b0, frame_done}, 0);
    chk({tag, "_timeout_err"}, {31'b0, timeout_err}, 0);
    chk({tag, "_mb_luma"}, mb_l, 0);
    chk({tag, "_mb_chromab"}, mb_b, 0);
    chk({tag, "_mb_chromar"}, mb_r, 0);
  endtask

  // Monitor: pops the scoreboard on every commit and checks output invariants.
  always @(negedge clk) begin
    if (!reset) begin
      chk("enabler_onehot0", ($countones(enabler) <= 1) ? 32'd1 : 32'd0, 1);
      chk("chroma_b_eq_r", mb_b, mb_r);
      if (res_ready) chk("enabler_in_wait", {29'b0, enabler}, 0);
      if (enabler[0]) begin
        lat_l = mb_l;
        lat_c = mb_b;
      end
      if (enabler[1] || enabler[2]) begin
        chk("mb_luma_stable", mb_l, lat_l);
        chk("mb_chroma_stable", mb_b, lat_c);
      end
      if (enabler[2]) begin
        commits++;
        if (commit_chroma) cc_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_luma", mb_l, e.luma);
          chk("commit_chroma_idx", mb_b, e.chroma);
          chk("commit_chroma_flag", {31'b0, commit_chroma}, {31'b0, e.cc});
        end
      end else begin
        chk("commit_chroma_outside", {31'b0, commit_chroma}, 0);
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_queue_empty", 32'(exp_q.size()), 0);
      end
    end
  end

  // One sub-block: residue handshake, extract, feedback at PREDICT offsets dl/db/dr.
  task automatic do_sub(input int n, input int rv_wait, input bit mid_start,
                        input int dl, input int db, input int dr, input bit early);
    int k, need;
    k = n % 4;
    need = dl;
    if (k == 0) begin
      if (db > need) need = db;
      if (dr > need) need = dr;
    end
    exp_q.push_back(model(n));
    chk("ready_in_wait", {31'b0, res_ready}, 1);
    for (int i = 0; i < rv_wait; i++) begin
      start = mid_start && (i == 3);
      step();
      start = 1'b0;
      chk("stall_ready", {31'b0, res_ready}, 1);
      chk("stall_enabler", {29'b0, enabler}, 0);
      chk("stall_busy", {31'b0, busy}, 1);
    end
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("extract", {29'b0, enabler}, 3'b001);
    if (early) begin
      fb_l = 1'b1; fb_b = 1'b1; fb_r = 1'b1;
    end
    step();
    for (int t = 0; t <= need; t++) begin
      chk("predict", {29'b0, enabler}, 3'b010);
      fb_l = (t == dl);
      fb_b = (t == db);
      fb_r = (t == dr);
      step();
    end
    fb_l = 1'b0; fb_b = 1'b0; fb_r = 1'b0;
    chk("commit", {29'b0, enabler}, 3'b100);
    chk("commit_cc", {31'b0, commit_chroma}, {31'b0, (k == 0)});
    step();
  endtask

  task automatic run_frame(input bit rnd);
    int d0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("frame_busy", {31'b0, busy}, 1);
    chk("frame_to_clear", {31'b0, timeout_err}, 0);
    for (int n = 0; n < NSUB; n++) begin
      if (!rnd)
        do_sub(n, 0, 0, 2, (n % 4 == 0) ? 2 : 99, (n % 4 == 0) ? 2 : 99, 0);
      else if (n == 0)
        do_sub(n, 0, 0, 1, 1, 6, 1);
      else if (n == 6)
        do_sub(n, 10, 1, 1, 0, 2, 0);
      else
        do_sub(n, $urandom_range(0, 3), 0, $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 1) == 1);
    end
    chk("frame_done_pulse", {31'b0, frame_done}, 1);
    chk("frame_end_busy", {31'b0, busy}, 0);
    chk("frame_end_enabler", {29'b0, enabler}, 0);
    d0 = done_cnt;
    step();
    chk("frame_done_single", {31'b0, frame_done}, 0);
    chk("frame_done_count", 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; res_valid = 1'b0;
    fb_l = 1'b0; fb_b = 1'b0; fb_r = 1'b0;
    repeat (3) step();
    check_all_zero("in_reset");
    reset = 1'b0;
    step();
    check_all_zero("idle");

    res_valid = 1'b1; fb_l = 1'b1; fb_b = 1'b1; fb_r = 1'b1;
    repeat (4) step();
    res_valid = 1'b0; fb_l = 1'b0; fb_b = 1'b0; fb_r = 1'b0;
    step();
    check_all_zero("no_start");

    run_frame(0);
    chk("frame1_commits", 32'(commits), 16);
    chk("frame1_chroma_commits", 32'(cc_cnt), 4);

    run_frame(1);

    // Timeout on sub-block 1, then restart clears the sticky flag.
    start = 1'b1;
    step();
    start = 1'b0;
    do_sub(0, 0, 0, 1, 1, 1, 0);
    chk("to_ready", {31'b0, res_ready}, 1);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("to_extract", {29'b0, enabler}, 3'b001);
    step();
    for (int t = 0; t < TO; t++) begin
      chk("to_predict", {29'b0, enabler}, 3'b010);
      step();
    end
    chk("to_err", {31'b0, timeout_err}, 1);
    chk("to_busy", {31'b0, busy}, 0);
    chk("to_enabler", {29'b0, enabler}, 0);
    chk("to_no_done", {31'b0, frame_done}, 0);
    d0 = done_cnt;
    step();
    chk("to_err_sticky", {31'b0, timeout_err}, 1);
    chk("to_idle_ready", {31'b0, res_ready}, 0);
    chk("to_done_count", 32'(done_cnt), 32'(d0));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_err_cleared", {31'b0, timeout_err}, 0);
    chk("to_restart_busy", {31'b0, busy}, 1);
    do_sub(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-frame while predicting sub-block 5.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    exp_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 5; n++) do_sub(n, 0, 0, 1, 2, 3, 0);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    step();
    chk("pre_reset_predict", {29'b0, enabler}, 3'b010);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    check_all_zero("after_reset");
    run_frame(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
